// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD (double dabble), one shift per clock, with leading-zero blanking and 9999 saturation.
// Latency BIN_W+1 clocks from the accepting START edge; START is ignored while BUSY (no queueing).
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK_50MHZ,
  input  logic                  RESET_N,
  input  logic [BIN_W-1:0]      BIN,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [DIGITS-1:0]     BLANK,
  output logic                  OVF
);

  localparam logic [31:0]       MAX_VAL    = 32'(10**DIGITS - 1);
  localparam int                CNT_W      = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST  = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

  state_t               state, state_nxt;
  logic [BIN_W-1:0]     shift_reg;
  logic [4*DIGITS-1:0]  scratch;
  logic [4*DIGITS-1:0]  scratch_adj;
  logic [4*DIGITS-1:0]  bcd_final;
  logic [DIGITS-1:0]    blank_final;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_int;
  logic                 accept;
  logic                 shift_en;
  logic                 finish;

  always_ff @(posedge CLOCK_50MHZ) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START) state_nxt = S_SHIFT;
      S_SHIFT:  if (cnt == LAST_SHIFT) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY     = (state != S_IDLE);
    accept   = (state == S_IDLE) && START;
    shift_en = (state == S_SHIFT);
    finish   = (state == S_FINISH);
  end

  // Add-3 correction applied to every nibble before the shift
  always_comb begin
    scratch_adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  // Saturated values are all 9s, so blanking naturally comes out all-zero under OVF
  always_comb begin
    logic zero_above;
    bcd_final   = ovf_int ? {DIGITS{4'h9}} : scratch;
    blank_final = '0;
    zero_above  = 1'b1;
    for (int k = DIGITS-1; k >= 1; k--) begin
      zero_above     = zero_above && (bcd_final[4*k +: 4] == 4'h0);
      blank_final[k] = zero_above;
    end
  end

  always_ff @(posedge CLOCK_50MHZ) begin
    if (!RESET_N) begin
      shift_reg <= '0;
      scratch   <= '0;
      cnt       <= '0;
      ovf_int   <= 1'b0;
      BCD       <= '0;
      BLANK     <= BLANK_RST;
      OVF       <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (accept) begin
        shift_reg <= BIN;
        scratch   <= '0;
        cnt       <= '0;
        ovf_int   <= (32'(BIN) > MAX_VAL);
      end else if (shift_en) begin
        // Carry out of the top digit is dropped; only overflowing inputs can produce one
        {scratch, shift_reg} <= {scratch_adj[4*DIGITS-2:0], shift_reg, 1'b0};
        cnt <= cnt + 1'b1;
      end else if (finish) begin
        BCD   <= bcd_final;
        BLANK <= blank_final;
        OVF   <= ovf_int;
        DONE  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed-vector bench for bin_to_bcd_seq with immediate-assertion checks.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] bin;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic        ovf;

  int n_total = 0;
  int n_pass  = 0;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .CLOCK_50MHZ (clk),
    .RESET_N     (rst_n),
    .BIN         (bin),
    .START       (start),
    .BUSY        (busy),
    .DONE        (done),
    .BCD         (bcd),
    .BLANK       (blank),
    .OVF         (ovf)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_conv(input string tag, input logic [13:0] v, input logic [15:0] exp_bcd,
                          input logic [3:0] exp_blank, input logic exp_ovf);
    int cyc;
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    wait_done(cyc);
    chk({tag, "_latency"}, cyc, 15);
    chk({tag, "_bcd"}, bcd, exp_bcd);
    chk({tag, "_blank"}, blank, exp_blank);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [15:0] exp_bcd;

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_blank", blank, 4'b1110);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();

    run_conv("v1234", 14'd1234, 16'h1234, 4'b0000, 1'b0);
    run_conv("v0", 14'd0, 16'h0000, 4'b1110, 1'b0);
    run_conv("v42", 14'd42, 16'h0042, 4'b1100, 1'b0);
    run_conv("v9999", 14'd9999, 16'h9999, 4'b0000, 1'b0);
    run_conv("v12000", 14'd12000, 16'h9999, 4'b0000, 1'b1);
    run_conv("v16383", 14'd16383, 16'h9999, 4'b0000, 1'b1);

    // START mid-conversion must be ignored
    bin   = 14'd500;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    bin   = 14'd777;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = 14'd0;
    pulses = 0;
    repeat (25) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_bcd", bcd, 16'h0500);
    chk("ign_blank", blank, 4'b1000);
    chk("ign_busy", busy, 0);

    // Reset on edge 5 aborts the conversion
    bin   = 14'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd, 16'h0000);
    chk("abort_blank", blank, 4'b1110);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    chk("abort_bcd_hold", bcd, 16'h0000);
    run_conv("v8", 14'd8, 16'h0008, 4'b1110, 1'b0);

    // START held high: conversions back to back every 16 cycles
    bin   = 14'd1;
    start = 1'b1;
    tick();
    for (int n = 1; n <= 20; n++) begin
      exp_bcd = 16'(((n / 10) << 4) | (n % 10));
      wait_done(cyc);
      chk($sformatf("held%0d_latency", n), cyc, 15);
      chk($sformatf("held%0d_bcd", n), bcd, exp_bcd);
      bin = 14'(n + 1);
      tick();
      chk($sformatf("held%0d_pulse", n), done, 0);
      chk($sformatf("held%0d_hold", n), bcd, exp_bcd);
    end
    start = 1'b0;
    repeat (20) tick();
    chk("final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
